// File: rtl/mult_pkg.sv
// Shared definitions for the shared shift-add multiplier front end:
// state encoding and default multiplier geometry.
package mult_pkg;

  localparam int MUL_WIDTH  = 4;
  localparam int MUL_PROD_W = 2 * MUL_WIDTH;
  localparam int ITER_CNT   = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared multiplier arbiter.
// master = arbiter, slave = surrounding requesters and multiplier.
interface mult_share_arbiter_if
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = MUL_WIDTH
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       gnt;
  logic                     rsp_valid;
  logic [NUM_REQ-1:0]       rsp_id;
  logic [2*WIDTH-1:0]       rsp_product;
  logic                     busy;
  logic                     mul_start;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_ready;
  logic [2*WIDTH-1:0]       mul_product;
  logic                     err;

  modport master (
    input  req, req_a, req_b, mul_ready, mul_product,
    output gnt, rsp_valid, rsp_id, rsp_product, busy,
           mul_start, mul_a, mul_b, err
  );

  modport slave (
    output req, req_a, req_b, mul_ready, mul_product,
    input  gnt, rsp_valid, rsp_id, rsp_product, busy,
           mul_start, mul_a, mul_b, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Returns a one-hot grant, its binary index and an any-request flag.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // scan N positions starting at ptr, first hit wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [IDX_W-1:0] cand_s;
      cand_s = IDX_W'((int'(ptr) + k) % N);
      if (!valid && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
        valid       = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier among NUM_REQ requesters, round-robin.
// Optional watchdog on the multiplier handshake: define MUL_TIMEOUT_EN.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = MUL_WIDTH,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_share_arbiter_if.master mif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PW    = 2 * WIDTH;

  state_t             state_r, next_s;
  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               arb_valid_s;
  logic               take_s;
  logic               tmo_hit_s;
  logic [IDX_W-1:0]   ptr_after_win_s;

  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nx_s;
  logic [IDX_W-1:0]   win_idx_r, win_idx_nx_s;
  logic [NUM_REQ-1:0] win_oh_r, win_oh_nx_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_nx_s;
  logic               mul_start_r, mul_start_nx_s;
  logic [WIDTH-1:0]   mul_a_r, mul_a_nx_s;
  logic [WIDTH-1:0]   mul_b_r, mul_b_nx_s;
  logic               rsp_valid_r, rsp_valid_nx_s;
  logic [NUM_REQ-1:0] rsp_id_r, rsp_id_nx_s;
  logic [PW-1:0]      rsp_product_r, rsp_product_nx_s;
  logic               err_r, err_nx_s;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (mif.req),
    .ptr   (rr_ptr_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  assign take_s          = (state_r == IDLE) && arb_valid_s && mif.mul_ready;
  assign ptr_after_win_s = (win_idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_r + IDX_W'(1);

`ifdef MUL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  assign tmo_hit_s = ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

  // watchdog counts cycles spent in one wait state, cleared on any transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if ((next_s == state_r) && ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE))) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // state and all output/datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      win_idx_r     <= '0;
      win_oh_r      <= '0;
      gnt_r         <= '0;
      mul_start_r   <= 1'b0;
      mul_a_r       <= '0;
      mul_b_r       <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_id_r      <= '0;
      rsp_product_r <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= next_s;
      rr_ptr_r      <= rr_ptr_nx_s;
      win_idx_r     <= win_idx_nx_s;
      win_oh_r      <= win_oh_nx_s;
      gnt_r         <= gnt_nx_s;
      mul_start_r   <= mul_start_nx_s;
      mul_a_r       <= mul_a_nx_s;
      mul_b_r       <= mul_b_nx_s;
      rsp_valid_r   <= rsp_valid_nx_s;
      rsp_id_r      <= rsp_id_nx_s;
      rsp_product_r <= rsp_product_nx_s;
      err_r         <= err_nx_s;
    end
  end

  // next-state logic; a completed handshake wins over a same-cycle timeout
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) next_s = LAUNCH;
        else        next_s = IDLE;
      end
      LAUNCH:    next_s = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!mif.mul_ready) next_s = WAIT_DONE;
        else if (tmo_hit_s) next_s = IDLE;
        else                next_s = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (mif.mul_ready)  next_s = RESP;
        else if (tmo_hit_s) next_s = IDLE;
        else                next_s = WAIT_DONE;
      end
      RESP:      next_s = IDLE;
      default:   next_s = IDLE;
    endcase
  end

  // next values of registered outputs; pulses are set one cycle ahead
  always_comb begin
    rr_ptr_nx_s      = rr_ptr_r;
    win_idx_nx_s     = win_idx_r;
    win_oh_nx_s      = win_oh_r;
    mul_a_nx_s       = mul_a_r;
    mul_b_nx_s       = mul_b_r;
    rsp_id_nx_s      = rsp_id_r;
    rsp_product_nx_s = rsp_product_r;
    gnt_nx_s         = '0;
    mul_start_nx_s   = 1'b0;
    rsp_valid_nx_s   = 1'b0;
    err_nx_s         = 1'b0;
    if (take_s) begin
      win_idx_nx_s   = arb_idx_s;
      win_oh_nx_s    = arb_gnt_s;
      mul_a_nx_s     = mif.req_a[arb_idx_s*WIDTH +: WIDTH];
      mul_b_nx_s     = mif.req_b[arb_idx_s*WIDTH +: WIDTH];
      gnt_nx_s       = arb_gnt_s;
      mul_start_nx_s = 1'b1;
    end else if ((state_r == WAIT_DONE) && mif.mul_ready) begin
      rsp_product_nx_s = mif.mul_product;
      rsp_id_nx_s      = win_oh_r;
      rr_ptr_nx_s      = ptr_after_win_s;
      rsp_valid_nx_s   = 1'b1;
    end else if (((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) && (next_s == IDLE)) begin
      rr_ptr_nx_s = ptr_after_win_s;
      err_nx_s    = 1'b1;
    end else begin
      err_nx_s = 1'b0;
    end
  end

  assign mif.gnt         = gnt_r;
  assign mif.mul_start   = mul_start_r;
  assign mif.mul_a       = mul_a_r;
  assign mif.mul_b       = mul_b_r;
  assign mif.rsp_valid   = rsp_valid_r;
  assign mif.rsp_id      = rsp_id_r;
  assign mif.rsp_product = rsp_product_r;
  assign mif.busy        = (state_r != IDLE);
  assign mif.err         = err_r;

endmodule
